// File: rtl/hazard_ctrl.sv
// Load-use stall, branch flush and syscall halt sequencing for the five-stage MIPS pipeline.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_ctrl #(
   parameter int LOAD_STALL_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  regfile_read_num1_id,
   input  logic [4:0]  regfile_read_num2_id,
   input  logic        uses_rs_id,
   input  logic        uses_rt_id,
   input  logic        MemRead_id_ex,
   input  logic [4:0]  regfile_write_num_id_ex,
   input  logic        branch_taken_ex,
   input  logic        halt_req_ex,
   input  logic        resume,
   output logic        nop_lock_id,
   output logic        pc_bj,
   output logic        flush_if_id,
   output logic        pc_hold,
   output logic        if_id_hold,
   output logic        halt_ex,
   output logic [31:0] load_stall_cnt,
   output logic [31:0] flush_cnt
);

   localparam logic [1:0] RUN    = 2'd0;
   localparam logic [1:0] LSTALL = 2'd1;
   localparam logic [1:0] HALTED = 2'd2;

   logic [1:0] state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       match;

   assign match = MemRead_id_ex && (regfile_write_num_id_ex != 5'd0) &&
                  ((uses_rs_id && (regfile_read_num1_id == regfile_write_num_id_ex)) ||
                   (uses_rt_id && (regfile_read_num2_id == regfile_write_num_id_ex)));

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      nop_lock_id = 1'b0;
      pc_bj       = 1'b0;
      flush_if_id = 1'b0;
      pc_hold     = 1'b0;
      if_id_hold  = 1'b0;
      case (state)
         HALTED: begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
            if (resume && !halt_req_ex) state_nxt = RUN;
         end
         default: begin
            // Flush beats stall: the stalled instruction is on the wrong path anyway.
            if (branch_taken_ex) begin
               pc_bj       = 1'b1;
               flush_if_id = 1'b1;
               state_nxt   = RUN;
               cnt_nxt     = 4'd0;
            end else if (state == LSTALL) begin
               nop_lock_id = 1'b1;
               pc_hold     = 1'b1;
               if_id_hold  = 1'b1;
               if (cnt <= 4'd1) begin
                  state_nxt = RUN;
                  cnt_nxt   = 4'd0;
               end else begin
                  cnt_nxt = cnt - 4'd1;
               end
            end else if (match) begin
               nop_lock_id = 1'b1;
               pc_hold     = 1'b1;
               if_id_hold  = 1'b1;
               if (LOAD_STALL_CYCLES > 1) begin
                  state_nxt = LSTALL;
                  cnt_nxt   = 4'(LOAD_STALL_CYCLES - 1);
               end
            end
            if (halt_req_ex) begin
               state_nxt = HALTED;
               cnt_nxt   = 4'd0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign halt_ex = (state == HALTED);

`ifdef HAZARD_STATS_EN
   logic [31:0] load_stall_q, flush_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         load_stall_q <= 32'd0;
         flush_q      <= 32'd0;
      end else begin
         load_stall_q <= load_stall_q + 32'(nop_lock_id);
         flush_q      <= flush_q + 32'(pc_bj);
      end
   end

   assign load_stall_cnt = load_stall_q;
   assign flush_cnt      = flush_q;
`else
   assign load_stall_cnt = 32'd0;
   assign flush_cnt      = 32'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. Generates the bubble, flush, hold and halt controls consumed by the IF/ID and ID/EX pipeline registers and the PC. It detects load-use hazards and stretches them to a configurable memory latency. It converts EX-stage branch/jump resolution into front-end flushes and sequences the syscall halt/resume state.

## Interface
- LOAD_STALL_CYCLES, 1, bubble cycles per load-use hazard (1..15)
- clk  input  1  core clock, all state on posedge
- rst  input  1  synchronous, active-high reset
- regfile_read_num1_id  input  5  rs number of instruction in ID
- regfile_read_num2_id  input  5  rt number of instruction in ID
- uses_rs_id  input  1  ID instruction reads rs
- uses_rt_id  input  1  ID instruction reads rt
- MemRead_id_ex  input  1  instruction in EX is a load
- regfile_write_num_id_ex  input  5  destination register of EX instruction
- branch_taken_ex  input  1  EX resolved a taken branch or jump this cycle
- halt_req_ex  input  1  EX holds a halting syscall this cycle
- resume  input  1  external restart request while halted
- nop_lock_id  output  1  insert bubble into ID/EX
- pc_bj  output  1  flush ID/EX; PC takes branch target
- flush_if_id  output  1  clear IF/ID to NOP
- pc_hold  output  1  PC keeps its value
- if_id_hold  output  1  IF/ID keeps its value
- halt_ex  output  1  halted; ID/EX loads syscall-halt pattern
- load_stall_cnt  output  32  load-use bubble cycles (stats)
- flush_cnt  output  32  flush events (stats)

## Operation
- States: RUN, LSTALL, HALTED. Reset: RUN, stall counter 0, all outputs 0, stats counters 0.
- Hazard match: MemRead_id_ex=1, regfile_write_num_id_ex≠0, and either (uses_rs_id and num1 equals it) or (uses_rt_id and num2 equals it).
- RUN, match, no flush:
  - nop_lock_id, pc_hold and if_id_hold are asserted combinationally.
  - If LOAD_STALL_CYCLES>1, the next state is LSTALL with counter = LOAD_STALL_CYCLES−1.
- LSTALL:
  - nop_lock_id, pc_hold and if_id_hold are held high. The counter decrements each cycle.
  - When the counter reaches 1 and is consumed, the next state is RUN.
  - A fresh match is not evaluated in LSTALL, because the bubble already occupies EX.
- branch_taken_ex=1 in RUN or LSTALL:
  - pc_bj=1 and flush_if_id=1 the same cycle, combinationally.
  - nop_lock_id, pc_hold and if_id_hold are forced 0. Flush wins over stall.
  - Counter is cleared and the next state is RUN.
- halt_req_ex=1 in RUN or LSTALL: next state is HALTED.
  - If branch_taken_ex is also 1, the flush is still issued that cycle.
- HALTED:
  - halt_ex=1 (registered), pc_hold=1, if_id_hold=1, pc_bj=0, nop_lock_id=0. All hazard inputs are ignored.
  - resume=1 returns to RUN the next cycle. halt_ex drops with the state.
  - halt_req_ex=1 together with resume: stay HALTED.
- Register 0 never creates a hazard.

## Timing
- Load-use: bubble count into ID/EX is exactly LOAD_STALL_CYCLES. The PC and IF/ID are frozen for the same cycles. The dependent instruction enters EX on the following edge.
- Flush: zero latency, same-cycle combinational path from branch_taken_ex. It removes exactly the two younger instructions (IF/ID and ID/EX).
- Halt: halt_ex asserts one cycle after halt_req_ex is sampled and persists until the cycle after resume is sampled.
- Reset mid-LSTALL or in HALTED: RUN with all outputs 0 on the next edge.
- LOAD_STALL_CYCLES=1: LSTALL is never entered.

## Configuration
- HAZARD_STATS_EN defined:
  - load_stall_cnt increments once per cycle with nop_lock_id=1.
  - flush_cnt increments once per cycle with pc_bj=1.
  - Both wrap modulo 2^32 and are cleared by rst.
- HAZARD_STATS_EN undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- lw $t0 in EX (MemRead=1, write num 8), ID reads rs=8, LOAD_STALL_CYCLES=1 -> nop_lock_id/pc_hold/if_id_hold high 1 cycle, then 0; load_stall_cnt=1.
- Same hazard with LOAD_STALL_CYCLES=3 -> controls high 3 consecutive cycles, state RUN after; counter=3.
- Load to $zero with ID reading rs=0, or rt match with uses_rt_id=0 -> no stall.
- branch_taken_ex=1 in the 2nd cycle of a 3-cycle stall -> pc_bj=flush_if_id=1 that cycle, stall controls 0, next cycle RUN with all 0; flush_cnt=1.
- halt_req_ex pulse -> halt_ex=1 from next cycle, pc_hold held; resume after 5 cycles -> halt_ex=0 next cycle; resume together with halt_req -> stays halted.
- rst asserted during LSTALL and during HALTED -> all outputs 0 next cycle; stats counters 0.
